// File: rtl/countdown_timer.sv
// -----------------------------------------------------------------------------
// countdown_timer
//
// Loadable down-counter with terminal-count detection. A start value is
// loaded, the counter decrements on enabled cycles, and a one-cycle expire
// pulse marks the edge on which it reaches terminal count.
//
// Build option:
//   COUNTDOWN_RELOAD_EN  defined     -> periodic mode: at terminal count the
//                                       counter reloads the last loaded value
//                                       and keeps running; DONE is unreachable.
//                        not defined -> one-shot mode: at terminal count the
//                                       counter goes to 0 and parks in DONE.
//
// Parameters:
//   WIDTH       counter width in bits (>= 2)
//
// Ports:
//   clock       in   rising-edge clock
//   reset       in   synchronous active-high reset, highest priority
//   load        in   capture load_value into counter and reload register
//   load_value  in   start value, sampled only when load = 1
//   enable      in   decrement permission, evaluated each edge
//   count       out  current counter value (registered)
//   busy        out  high while in RUN (registered)
//   done        out  high while in DONE (registered)
//   expire      out  one-cycle terminal-count pulse (registered)
// -----------------------------------------------------------------------------
module countdown_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             expire
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic             r_busy;
  logic             r_done;
  logic             r_expire;

`ifdef COUNTDOWN_RELOAD_EN
  // Only periodic mode ever reads the reload value back, so the register
  // exists only in that build.
  logic [WIDTH-1:0] r_reload;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_expire <= 1'b0;
`ifdef COUNTDOWN_RELOAD_EN
      r_reload <= '0;
`endif
    end else begin
      // Pulse defaults low; only a terminal-count edge raises it.
      r_expire <= 1'b0;

      if (load) begin
        // Load overrides any decrement or terminal count on the same edge,
        // so an in-progress count is abandoned without an expire.
        r_count <= load_value;
`ifdef COUNTDOWN_RELOAD_EN
        r_reload <= load_value;
`endif
        r_done  <= 1'b0;
        if (load_value != '0) begin
          r_state <= S_RUN;
          r_busy  <= 1'b1;
        end else begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      end else if (r_state == S_RUN && enable) begin
        if (r_count == ONE) begin
          r_expire <= 1'b1;
`ifdef COUNTDOWN_RELOAD_EN
          r_count  <= r_reload;
`else
          r_count  <= '0;
          r_state  <= S_DONE;
          r_busy   <= 1'b0;
          r_done   <= 1'b1;
`endif
        end else begin
          // RUN is only entered with a non-zero value, so count >= 2 here.
          r_count <= r_count - ONE;
        end
      end
      // IDLE/DONE without load, or RUN without enable: hold everything.
    end
  end

  assign count  = r_count;
  assign busy   = r_busy;
  assign done   = r_done;
  assign expire = r_expire;

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Loadable down-counter with terminal-count detection; the decrementing counterpart to the team's 4-bit enable-gated up-counter. Software or a sequencer loads a start value, and the block counts down on enabled cycles. On reaching zero it emits a one-cycle `expire` pulse. It serves as the timeout/delay element beside the up-counter in simulation testbenches and small controllers.

## Interface
Parameters:
- `WIDTH`, 4, counter width in bits (≥2)

Ports:
- `clock` in 1: rising-edge clock; all state changes on posedge
- `reset` in 1: synchronous, active-high reset; highest priority
- `load` in 1: capture `load_value` into counter and reload register
- `load_value` in WIDTH: start value, sampled only when `load`=1
- `enable` in 1: decrement permission, evaluated each posedge
- `count` out WIDTH: current counter value, registered
- `busy` out 1: high while in RUN
- `done` out 1: high while in DONE
- `expire` out 1: one-cycle pulse on terminal count, registered

## Operation
- States: IDLE, RUN, DONE.
- Reset (posedge with `reset`=1): state IDLE; `count`=0; reload register 0; `busy`=0; `done`=0; `expire`=0. `load` and `enable` are ignored.
- Priority per edge: reset > load > enable decrement > hold.
- `load`=1 with `load_value`≠0, from any state: `count`←`load_value`, reload←`load_value`, state RUN. An in-progress count is aborted with no `expire`.
- `load`=1 with `load_value`=0: `count`←0, reload←0, state IDLE, no `expire`.
- RUN, `enable`=1, `count`>1: `count`←`count`−1.
- RUN, `enable`=1, `count`=1: terminal count. `expire`←1 for one cycle; behaviour then depends on the Configuration section.
- RUN, `enable`=0: `count` holds; no state change.
- IDLE/DONE with `enable`=1 and no `load`: no change. The counter never decrements below 0 and never wraps to all-ones.
- `expire` is 0 on every edge except a terminal-count edge.
- `load` and terminal count on the same edge: load wins and `expire` stays 0.
- `busy`=(state==RUN); `done`=(state==DONE). Both are registered with the state.
- Arithmetic is WIDTH bits, unsigned. Maximum load value is 2^WIDTH−1, giving 2^WIDTH−1 enabled cycles to expiry.

## Timing
- All outputs update on the posedge where their cause is sampled: latency 1 clock from input to output.
- With `load`=N at edge k, then continuous `enable`, `count`=N after edge k. `expire`=1 after edge k+N (count N−1 … 0 over N edges).
- `expire` width is exactly one clock, even when `enable` stays high.
- If `reset` is asserted mid-count, IDLE/0 follows the next edge. A pending `expire` is suppressed.
- There are no combinational input→output paths.

## Configuration
- `COUNTDOWN_RELOAD_EN` defined: at terminal count, `count`←reload register and state stays RUN (periodic mode). `expire` pulses every N enabled cycles. DONE is unreachable; `done` stays 0.
- `COUNTDOWN_RELOAD_EN` not defined: at terminal count, `count`←0 and state→DONE (one-shot). `done`=1 until the next `load` or `reset`.

## Test plan
- Reset: hold `reset`=1 for 3 clocks with `load`=1, `load_value`=9 -> after every edge `count`=0, `busy`=0, `done`=0, `expire`=0.
- One-shot: `load`=1, `load_value`=5, then `enable`=1 continuously -> `count` 5,4,3,2,1,0 on successive edges. `expire`=1 only on the edge where `count` becomes 0. Then `done`=1, and `count` stays 0 for 10 more clocks (no macro).
- Enable gating: `load_value`=4; `enable` pattern 1,0,0,1,1,1 -> `count` 4,3,3,3,2,1,0. `expire` occurs on the 6th post-load edge only.
- Reload: with `COUNTDOWN_RELOAD_EN`, `load_value`=3, `enable`=1 for 9 edges -> `expire` on edges 3, 6 and 9. `count` sequence is 2,1,3,2,1,3,2,1,3; `busy` stays 1.
- Collisions: with `count`=1 and `enable`=1, assert `load`=1, `load_value`=7 -> `count`=7, `expire`=0, `busy`=1. Separately, `load_value`=0 -> state IDLE, `count`=0, no `expire`.
- Mid-run reset: with `load_value`=15, after 6 enabled edges assert `reset` -> `count`=0, `busy`=0, no `expire`.
